time_countdown4: RTL and testbench

- Four-digit BCD MM:SS countdown timer. It is the down-counting counterpart to the lab's two-digit up-counting BCD time counter.
- Loads a preset, decrements once per second to 00:00, then raises done.
- Contains its own 1 Hz tick prescaler (clock-enable style, no derived clocks).
- Feeds the seven-segment display scanner and the alarm/LED logic.

---
 rtl/time_countdown4.sv | 139 +++++++++++++
 tb/tb_time_countdown4.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_countdown4.sv
// Four-digit BCD MM:SS countdown timer with a built-in clock-enable prescaler.
// Loads a clamped preset, decrements once per tick while running, raises done at 00:00.
module time_countdown4 #(
  parameter int TICK_DIV = 100000000,
  parameter int PW       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic [3:0] set_m1,
  input  logic [3:0] set_m0,
  input  logic [3:0] set_s1,
  input  logic [3:0] set_s0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic [1:0] o_dbg_state
);

  // Debug encoding of o_dbg_state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_m1, r_m0, r_s1, r_s0;
  logic          r_running, r_done, r_tick;

  logic [1:0] w_state_nx;
  logic       w_fire;
  logic       w_zero, w_one;
  logic [3:0] w_ld_m1, w_ld_m0, w_ld_s1, w_ld_s0;
  logic [3:0] w_dc_m1, w_dc_m0, w_dc_s1, w_dc_s0;

  assign w_zero = ({r_m1, r_m0, r_s1, r_s0} == 16'h0000);
  assign w_one  = ({r_m1, r_m0, r_s1, r_s0} == 16'h0001);

  assign w_ld_m1 = (set_m1 > 4'd9) ? 4'd9 : set_m1;
  assign w_ld_m0 = (set_m0 > 4'd9) ? 4'd9 : set_m0;
  assign w_ld_s1 = (set_s1 > 4'd5) ? 4'd5 : set_s1;
  assign w_ld_s0 = (set_s0 > 4'd9) ? 4'd9 : set_s0;

  // load beats start; start beats the prescaler terminal count (pause wins).
  always_comb begin
    w_state_nx = r_state;
    w_fire     = 1'b0;
    if (load) begin
      w_state_nx = S_IDLE;
    end else if (start) begin
      case (r_state)
        S_IDLE:  w_state_nx = w_zero ? S_DONE : S_RUN;
        S_RUN:   w_state_nx = S_PAUSE;
        S_PAUSE: w_state_nx = S_RUN;
        default: w_state_nx = r_state;
      endcase
    end else if (r_state == S_RUN && r_presc == TERM) begin
      w_fire = 1'b1;
      if (w_one) w_state_nx = S_DONE;
    end
  end

  // MM:SS borrow chain; m1 never underflows since counting stops at 00:00.
  always_comb begin
    w_dc_m1 = r_m1;
    w_dc_m0 = r_m0;
    w_dc_s1 = r_s1;
    w_dc_s0 = r_s0;
    if (r_s0 != 4'd0) begin
      w_dc_s0 = r_s0 - 4'd1;
    end else begin
      w_dc_s0 = 4'd9;
      if (r_s1 != 4'd0) begin
        w_dc_s1 = r_s1 - 4'd1;
      end else begin
        w_dc_s1 = 4'd5;
        if (r_m0 != 4'd0) begin
          w_dc_m0 = r_m0 - 4'd1;
        end else begin
          w_dc_m0 = 4'd9;
          w_dc_m1 = r_m1 - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_m1      <= 4'd0;
      r_m0      <= 4'd0;
      r_s1      <= 4'd0;
      r_s0      <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_running <= (w_state_nx == S_RUN);
      r_done    <= (w_state_nx == S_DONE);
      r_tick    <= w_fire;
      if (load) begin
        r_m1 <= w_ld_m1;
        r_m0 <= w_ld_m0;
        r_s1 <= w_ld_s1;
        r_s0 <= w_ld_s0;
      end else if (w_fire) begin
        r_m1 <= w_dc_m1;
        r_m0 <= w_dc_m0;
        r_s1 <= w_dc_s1;
        r_s0 <= w_dc_s0;
      end
      // Any entry into RUN (start or resume) begins a full tick period.
      if (r_state == S_RUN && w_state_nx == S_RUN && !w_fire)
        r_presc <= r_presc + PW'(1);
      else
        r_presc <= '0;
    end
  end

  assign m1          = r_m1;
  assign m0          = r_m0;
  assign s1          = r_s1;
  assign s0          = r_s0;
  assign running     = r_running;
  assign done        = r_done;
  assign tick        = r_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_time_countdown4.sv
// Bench for time_countdown4: a seconds-based reference model, directed scenario
// tasks, a tick scoreboard and a randomized load/start run.
module tb_time_countdown4;

  localparam int TD = 4;
  localparam int MI = 0, MR = 1, MP = 2, MD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0;
  logic start = 1'b0;
  logic [3:0] set_m1 = 4'd0, set_m0 = 4'd0, set_s1 = 4'd0, set_s0 = 4'd0;
  wire  [3:0] m1, m0, s1, s0;
  wire        running, done, tick;
  wire  [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  int   m_secs = 0;
  int   m_mode = MI;
  int   m_phase = 0;
  logic m_tick = 1'b0;

  wire [20:0] obs = {m1, m0, s1, s0, running, done, tick, dbg_state};

  always #5 clk = ~clk;

  time_countdown4 #(.TICK_DIV(TD), .PW(3)) dut (
    .clk(clk), .rst(rst), .load(load), .start(start),
    .set_m1(set_m1), .set_m0(set_m0), .set_s1(set_s1), .set_s0(set_s0),
    .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .running(running), .done(done), .tick(tick), .o_dbg_state(dbg_state)
  );

  function automatic int clamp_secs(input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] c, input logic [3:0] d);
    int x1 = (a > 9) ? 9 : int'(a);
    int x0 = (b > 9) ? 9 : int'(b);
    int y1 = (c > 5) ? 5 : int'(c);
    int y0 = (d > 9) ? 9 : int'(d);
    return (x1 * 10 + x0) * 60 + y1 * 10 + y0;
  endfunction

  function automatic logic [15:0] secs_bcd(input int s);
    int mn = s / 60;
    int sc = s % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic logic [20:0] exp_vec();
    return {secs_bcd(m_secs), m_mode == MR, m_mode == MD, m_tick, 2'(m_mode)};
  endfunction

  // Reference model: remaining time in whole seconds plus cycles spent in RUN.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_secs = 0; m_mode = MI; m_phase = 0; m_tick = 1'b0;
      exp_q.delete();
    end else begin
      m_tick = 1'b0;
      if (load) begin
        m_secs = clamp_secs(set_m1, set_m0, set_s1, set_s0);
        m_mode = MI; m_phase = 0;
      end else if (start) begin
        if (m_mode == MI) m_mode = (m_secs == 0) ? MD : MR;
        else if (m_mode == MR) m_mode = MP;
        else if (m_mode == MP) m_mode = MR;
        m_phase = 0;
      end else if (m_mode == MR) begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_secs--;
          m_tick = 1'b1;
          exp_q.push_back(secs_bcd(m_secs));
          if (m_secs == 0) m_mode = MD;
        end
      end
    end
  end

  // Tick scoreboard: every DUT tick must match the next model decrement.
  always @(negedge clk) begin : tick_sb
    logic [15:0] e;
    if (rst && tick) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tick_sb: got tick with count %h, expected no tick", {m1, m0, s1, s0});
      end else begin
        e = exp_q.pop_front();
        if ({m1, m0, s1, s0} !== e) begin
          miscompares++;
          $display("FAIL tick_sb: got count %h, expected %h", {m1, m0, s1, s0}, e);
        end
      end
    end
  end

  task automatic set_preset(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    set_m1 = a; set_m0 = b; set_s1 = c; set_s0 = d;
  endtask

  task automatic cyc(input logic ld, input logic st);
    load = ld; start = st;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (obs !== 21'h0) begin
      miscompares++; $display("FAIL reset_hold: got %h expected %h", obs, 21'h0);
    end
    rst = 1'b1;
    cyc(0, 0);
    vectors++;
    if (obs !== exp_vec() || obs !== 21'h0) begin
      miscompares++; $display("FAIL idle_after_reset: got %h expected %h", obs, exp_vec());
    end
    set_preset(0, 0, 0, 0);
    cyc(1, 0);
    cyc(0, 1);
    vectors++;
    if (done !== 1'b1 || tick !== 1'b0 || running !== 1'b0 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL zero_start_done: got %h expected %h", obs, exp_vec());
    end
    repeat (3) begin
      cyc(0, 0);
      vectors++;
      if (tick !== 1'b0 || done !== 1'b1) begin
        miscompares++; $display("FAIL zero_hold: got tick %b done %b expected 0 1", tick, done);
      end
    end
  endtask

  task automatic test_basic_count();
    set_preset(0, 0, 0, 3);
    cyc(1, 0);
    cyc(0, 1);
    repeat (16) begin
      cyc(0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL basic_count: got %h expected %h", obs, exp_vec());
      end
    end
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
      miscompares++; $display("FAIL basic_final: got %h/%b expected 0000/1", {m1, m0, s1, s0}, done);
    end
  endtask

  task automatic test_borrow();
    set_preset(1, 0, 0, 0);
    cyc(1, 0);
    cyc(0, 1);
    repeat (4) cyc(0, 0);
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h0959 || tick !== 1'b1 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL borrow_10_00: got %h expected 0959 with tick", {m1, m0, s1, s0});
    end
    set_preset(0, 1, 0, 0);
    cyc(1, 0);
    cyc(0, 1);
    repeat (4) cyc(0, 0);
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h0059 || tick !== 1'b1 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL borrow_01_00: got %h expected 0059 with tick", {m1, m0, s1, s0});
    end
  endtask

  task automatic test_pause_resume();
    set_preset(0, 0, 0, 5);
    cyc(1, 0);
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);
    repeat (20) begin
      cyc(0, 0);
      vectors++;
      if ({m1, m0, s1, s0} !== 16'h0005 || running !== 1'b0 || obs !== exp_vec()) begin
        miscompares++; $display("FAIL pause_frozen: got %h expected %h", obs, exp_vec());
      end
    end
    cyc(0, 1);
    repeat (3) begin
      cyc(0, 0);
      vectors++;
      if (tick !== 1'b0 || running !== 1'b1) begin
        miscompares++; $display("FAIL resume_wait: got tick %b running %b expected 0 1", tick, running);
      end
    end
    cyc(0, 0);
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h0004 || tick !== 1'b1 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL resume_tick: got %h expected 0004 with tick", {m1, m0, s1, s0});
    end
  endtask

  task automatic test_priority_clamp();
    set_preset(0, 0, 3, 0);
    cyc(1, 0);
    cyc(0, 1);
    repeat (2) cyc(0, 0);
    set_preset(4'h7, 4'h9, 4'h8, 4'hB);
    cyc(1, 1);
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h7959 || running !== 1'b0 || done !== 1'b0 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL load_over_start: got %h expected %h", obs, exp_vec());
    end
    cyc(0, 1);
    repeat (3) cyc(0, 0);
    cyc(0, 1);
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h7959 || tick !== 1'b0 || running !== 1'b0 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL pause_at_terminal: got %h expected %h", obs, exp_vec());
    end
    repeat (6) begin
      cyc(0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL pause_hold: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    set_preset(0, 0, 0, 9);
    cyc(1, 0);
    cyc(0, 1);
    repeat (6) cyc(0, 0);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs !== 21'h0 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL async_reset: got %h expected %h", obs, 21'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0);
    cyc(0, 1);
    vectors++;
    if ({m1, m0, s1, s0} !== 16'h0000 || done !== 1'b1 || running !== 1'b0 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL start_after_reset: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic ld, st;
    repeat (400) begin
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 5) == 0);
      if (ld) begin
        if ($urandom_range(0, 3) == 0)
          set_preset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else
          set_preset(4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      cyc(ld, st);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL random: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_borrow();
    test_pause_resume();
    test_priority_clamp();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL tick_sb_drain: got %0d pending ticks expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
